// File: rtl/div_iter_unit_pkg.sv
// Shared constants, state encoding and operand helper for the iterative divider.
package div_iter_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

    // Magnitude of a signed operand; 0x8000_0000 maps to itself as unsigned.
    function automatic logic [31:0] abs32(input logic is_signed, input logic [31:0] v);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter_unit_step.sv
// One radix-2 restoring division step: trial subtract, keep or restore.
module div_step
    import div_iter_unit_pkg::*;
(
    input  logic [32:0] partial,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic        q_bit
);
    logic [32:0] diff;

    // Partial remainder is always below 2*divisor, so bit 32 is a valid sign.
    assign diff     = partial - {1'b0, divisor};
    assign q_bit    = ~diff[32];
    assign rem_next = diff[32] ? partial[31:0] : diff[31:0];

endmodule

// File: rtl/div_iter_unit.sv
// Iterative 32-bit signed/unsigned divider; result is {remainder, quotient}.
// Define DIV_BYZERO_FAST_EN to short-circuit zero divisors in two cycles.
module div_iter_unit
    import div_iter_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);
    div_state_e  state, state_next;
    logic [4:0]  cnt;
    logic [31:0] rem;
    logic [31:0] dvd;      // dividend bits shift out the top, quotient bits shift in
    logic [31:0] dsr;
    logic        neg_q, neg_r;

    logic [31:0] rem_next;
    logic        q_bit;
    logic [31:0] q_full;
    logic [31:0] q_fix, r_fix;

    div_step u_step (
        .partial  ({rem, dvd[31]}),
        .divisor  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign q_full = {dvd[30:0], q_bit};
    assign q_fix  = neg_q ? (~q_full + 32'd1) : q_full;
    assign r_fix  = neg_r ? (~rem_next + 32'd1) : rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DivFree;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
`ifdef DIV_BYZERO_FAST_EN
                    state_next = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
`else
                    state_next = DivOn;
`endif
                end
            end
            DivByZero: state_next = DivEnd;
            DivOn:     if (cnt == 5'd31) state_next = DivEnd;
            DivEnd:    if (start_i == DivStop) state_next = DivFree;
            default:   state_next = DivFree;
        endcase
        if (annul_i) state_next = DivFree;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 5'd0;
            rem      <= ZeroWord;
            dvd      <= ZeroWord;
            dsr      <= ZeroWord;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= {ZeroWord, ZeroWord};
            ready_o  <= DivResultNotReady;
        end else if (annul_i) begin
            ready_o <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    if (start_i == DivStart) begin
                        cnt   <= 5'd0;
                        rem   <= ZeroWord;
                        dvd   <= abs32(signed_div_i, opdata1_i);
                        dsr   <= abs32(signed_div_i, opdata2_i);
                        neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r <= signed_div_i & opdata1_i[31];
`ifdef DIV_BYZERO_FAST_EN
                        // Raw dividend is reported unmodified on the fast path.
                        if (opdata2_i == ZeroWord) dvd <= opdata1_i;
`endif
                    end
                end
                DivByZero: begin
                    result_o <= {dvd, 32'hFFFF_FFFF};
                    ready_o  <= DivResultReady;
                end
                DivOn: begin
                    rem <= rem_next;
                    dvd <= q_full;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        result_o <= {r_fix, q_fix};
                        ready_o  <= DivResultReady;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) ready_o <= DivResultNotReady;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed table, corner sequences, random ops.
module tb_div_iter_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    div_iter_unit dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: magnitude division with plain operators, then sign rules.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        logic        na, nb;
        na = sg && a[31];
        nb = sg && b[31];
        ua = na ? 32'(-a) : a;
        ub = nb ? 32'(-b) : b;
        if (ub == 0) begin
            q = 32'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (na ^ nb) q = 32'(-q);
        if (na)      r = 32'(-r);
        return {r, q};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_BYZERO_FAST_EN
        if (b == 0) return 2;
`endif
        return 33;
    endfunction

    // Standard requester: hold start until ready, then drop it. Operands are
    // scrambled after sampling to confirm they are not looked at again.
    task automatic run_op(input string name, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int hold);
        int  n;
        bit  got;
        @(negedge clk);
        signed_div_i = sg; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        n = 0; got = 0;
        while (n < 100 && !got) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sg; end
            if (ready_o) got = 1;
        end
        chk({name, " latency"}, 64'(n), 64'(exp_lat(b)));
        chk({name, " result"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, " held ready"}, {63'd0, ready_o}, 64'd1);
            chk({name, " held result"}, result_o, exp);
        end
        @(negedge clk); start_i = 1'b0;
        @(posedge clk); #1;
        chk({name, " ready drop"}, {63'd0, ready_o}, 64'd0);
        chk({name, " result kept"}, result_o, exp);
    endtask

    initial begin
        logic [63:0] prev;
        logic        sg;
        logic [31:0] a, b;
        int          n;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000};
        vecs[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000};
        vecs[5] = '{1'b0, 32'h1234_5678,  32'd0,          64'h12345678_FFFFFFFF};
        vecs[6] = '{1'b0, 32'd9,          32'd3,          64'h00000000_00000003};

        #12;
        chk("reset ready", {63'd0, ready_o}, 64'd0);
        chk("reset result", result_o, 64'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

        // Start held through END: ready and result stay, no restart.
        run_op("hold", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 4);
        repeat (40) @(posedge clk);
        #1 chk("no restart", {63'd0, ready_o}, 64'd0);

        // Annul in cycle 10 of ON: back to idle, result untouched.
        prev = result_o;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        chk("annul ready", {63'd0, ready_o}, 64'd0);
        chk("annul result", result_o, prev);
        @(negedge clk); annul_i = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk("annul no finish", {63'd0, ready_o}, 64'd0);
        chk("annul result still", result_o, prev);
        run_op("after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0);

        // Annul together with start in idle: request ignored.
        prev = result_o;
        @(negedge clk);
        opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk("annul+start ready", {63'd0, ready_o}, 64'd0);
        chk("annul+start result", result_o, prev);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("async rst ready", {63'd0, ready_o}, 64'd0);
        chk("async rst result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk); rst = 1'b0;
        run_op("after rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            n  = int'($urandom_range(0, 5));
            case (n)
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 15);
                3: b = 32'(-$urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (i % 7 == 3) a = 32'h8000_0000;
            run_op($sformatf("rand%0d", i), sg, a, b, ref_div(sg, a, b), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
